// File: rtl/bicintp_vcal.sv
// Vertical 4-tap bicubic filter: multiply, pairwise add, round/clamp, with a
// per-frame saturation counter. All three stages stall together on backpressure.
module bicintp_vcal #(
    parameter int PIX_W = 8,
    parameter int WT_W  = 8,
    parameter int SHIFT = 7
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic             i_sof,
    input  logic             i_eol,
    input  logic [PIX_W-1:0] pix_0,
    input  logic [PIX_W-1:0] pix_1,
    input  logic [PIX_W-1:0] pix_2,
    input  logic [PIX_W-1:0] pix_3,
    input  logic [WT_W-1:0]  w_y_0,
    input  logic [WT_W-1:0]  w_y_1,
    input  logic [WT_W-1:0]  w_y_2,
    input  logic [WT_W-1:0]  w_y_3,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic [PIX_W-1:0] o_pix,
    output logic             o_sof,
    output logic             o_eol,
    output logic [15:0]      sat_cnt
);

    localparam int P_W = PIX_W + 1 + WT_W;  // zero-extended pixel times signed weight
    localparam int S_W = P_W + 1;
    localparam int T_W = S_W + 1;
    localparam logic signed [T_W-1:0] ROUND = T_W'(2 ** (SHIFT - 1));

    logic                    w_adv;
    logic [PIX_W-1:0]        w_pix  [4];
    logic [WT_W-1:0]         w_wt   [4];
    logic signed [P_W-1:0]   w_prod [4];
    logic signed [S_W-1:0]   w_s01;
    logic signed [S_W-1:0]   w_s23;
    logic signed [T_W-1:0]   w_t;
    logic signed [T_W-1:0]   w_t_rnd;
    logic signed [T_W-1:0]   w_r;
    logic                    w_under;
    logic                    w_over;
    logic                    w_sat;
    logic [PIX_W-1:0]        w_clamp;

    logic                    r_s1_vld;
    logic                    r_s1_sof;
    logic                    r_s1_eol;
    logic signed [P_W-1:0]   r_p [4];
    logic                    r_s2_vld;
    logic                    r_s2_sof;
    logic                    r_s2_eol;
    logic signed [S_W-1:0]   r_s01;
    logic signed [S_W-1:0]   r_s23;

    assign w_adv = o_rdy | ~o_vld;
    assign i_rdy = w_adv;

    assign w_pix[0] = pix_0;
    assign w_pix[1] = pix_1;
    assign w_pix[2] = pix_2;
    assign w_pix[3] = pix_3;
    assign w_wt[0]  = w_y_0;
    assign w_wt[1]  = w_y_1;
    assign w_wt[2]  = w_y_2;
    assign w_wt[3]  = w_y_3;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_prod[i] = '0;
            w_prod[i] = P_W'($signed({1'b0, w_pix[i]})) * P_W'($signed(w_wt[i]));
        end
    end

    assign w_s01   = S_W'(r_p[0]) + S_W'(r_p[1]);
    assign w_s23   = S_W'(r_p[2]) + S_W'(r_p[3]);
    assign w_t     = T_W'(r_s01) + T_W'(r_s23);
    assign w_t_rnd = w_t + ROUND;
    assign w_r     = w_t_rnd >>> SHIFT;

    // Negative results clamp to 0; anything with bits above the pixel range clamps to full scale.
    assign w_under = w_r[T_W-1];
    assign w_over  = ~w_r[T_W-1] & (|w_r[T_W-2:PIX_W]);
    assign w_sat   = w_under | w_over;

    always_comb begin
        w_clamp = w_r[PIX_W-1:0];
        if (w_under) begin
            w_clamp = '0;
        end else if (w_over) begin
            w_clamp = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_sof <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_sof <= 1'b0;
            r_s2_eol <= 1'b0;
            o_vld    <= 1'b0;
            o_pix    <= '0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= i_vld;
            r_s1_sof <= i_vld & i_sof;
            r_s1_eol <= i_vld & i_eol;
            r_s2_vld <= r_s1_vld;
            r_s2_sof <= r_s1_sof;
            r_s2_eol <= r_s1_eol;
            o_vld    <= r_s2_vld;
            o_pix    <= w_clamp;
            o_sof    <= r_s2_sof;
            o_eol    <= r_s2_eol;
        end
    end

    // NOTE: inner datapath registers carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge sys_clk) begin
        if (w_adv) begin
            for (int i = 0; i < 4; i++) begin
                r_p[i] <= w_prod[i];
            end
            r_s01 <= w_s01;
            r_s23 <= w_s23;
        end
    end

    // A frame start restarts the count with its own clamp event; the count sticks at all-ones.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sat_cnt <= '0;
        end else if (w_adv && r_s2_vld) begin
            if (r_s2_sof) begin
                sat_cnt <= {15'd0, w_sat};
            end else if (w_sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bicintp_vcal.sv
// Scoreboard bench for bicintp_vcal: stimulus pushes expected pixels/sideband,
// a negedge monitor pops and compares on every output transfer.
module tb_bicintp_vcal;

    logic        sys_clk;
    logic        sys_rst;
    logic        i_vld;
    logic        i_rdy;
    logic        i_sof;
    logic        i_eol;
    logic [7:0]  pix_0, pix_1, pix_2, pix_3;
    logic [7:0]  w_y_0, w_y_1, w_y_2, w_y_3;
    logic        o_vld;
    logic        o_rdy;
    logic [7:0]  o_pix;
    logic        o_sof;
    logic        o_eol;
    logic [15:0] sat_cnt;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        bit         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   bp_en  = 0;
    int   bp_ph  = 0;
    bit   held   = 0;
    logic [7:0] held_pix = '0;

    bicintp_vcal dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_vld   (i_vld),
        .i_rdy   (i_rdy),
        .i_sof   (i_sof),
        .i_eol   (i_eol),
        .pix_0   (pix_0),
        .pix_1   (pix_1),
        .pix_2   (pix_2),
        .pix_3   (pix_3),
        .w_y_0   (w_y_0),
        .w_y_1   (w_y_1),
        .w_y_2   (w_y_2),
        .w_y_3   (w_y_3),
        .o_vld   (o_vld),
        .o_rdy   (o_rdy),
        .o_pix   (o_pix),
        .o_sof   (o_sof),
        .o_eol   (o_eol),
        .sat_cnt (sat_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares transfers against the scoreboard and checks that a stalled output holds.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_vld", 32'(o_vld), 32'd1);
                check("hold_pix", 32'(o_pix), 32'(held_pix));
            end
            if (o_vld && !o_rdy) begin
                check("stall_i_rdy", 32'(i_rdy), 32'd0);
            end
            if (o_vld && o_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pix %0d with no expected entry (cycle %0d)", o_pix, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("o_pix", 32'(o_pix), 32'(e.pix));
                    check("o_sof", 32'(o_sof), 32'(e.sof));
                    check("o_eol", 32'(o_eol), 32'(e.eol));
                    if (e.lat) begin
                        check("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end
            end
            held     = o_vld && !o_rdy;
            held_pix = o_pix;
        end
    end

    // Backpressure generator: toggles o_rdy every two cycles while enabled.
    always begin
        @(posedge sys_clk);
        #1;
        if (bp_en) begin
            bp_ph++;
            if (bp_ph == 2) begin
                o_rdy = ~o_rdy;
                bp_ph = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int p0, input int p1, input int p2, input int p3,
                        input int w0, input int w1, input int w2, input int w3,
                        input bit sof, input bit eol, input bit lat, input int ep);
        bit done;
        done  = 1'b0;
        pix_0 = 8'(p0);
        pix_1 = 8'(p1);
        pix_2 = 8'(p2);
        pix_3 = 8'(p3);
        w_y_0 = 8'(w0);
        w_y_1 = 8'(w1);
        w_y_2 = 8'(w2);
        w_y_3 = 8'(w3);
        i_sof = sof;
        i_eol = eol;
        i_vld = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge sys_clk);
            if (i_rdy) begin
                exp_t e;
                e.pix = 8'(ep);
                e.sof = sof;
                e.eol = eol;
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
                @(posedge sys_clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got i_rdy %0d expected 1 within 200 cycles", i_rdy);
        end
        i_vld = 1'b0;
        i_sof = 1'b0;
        i_eol = 1'b0;
    endtask

    task automatic sendw(input int p0, input int p1, input int p2, input int p3,
                         input int w0, input int w1, input int w2, input int w3,
                         input bit sof, input int ep, input int exp_cnt);
        send(p0, p1, p2, p3, w0, w1, w2, w3, sof, 1'b0, 1'b1, ep);
        idle(4);
        check("sat_cnt", 32'(sat_cnt), 32'(exp_cnt));
    endtask

    initial begin
        sys_rst = 1'b1;
        i_vld   = 1'b0;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        {pix_0, pix_1, pix_2, pix_3} = '0;
        {w_y_0, w_y_1, w_y_2, w_y_3} = '0;
        o_rdy   = 1'b1;
        idle(2);
        check("rst_o_vld", 32'(o_vld), 32'd0);
        check("rst_o_pix", 32'(o_pix), 32'd0);
        check("rst_o_sof", 32'(o_sof), 32'd0);
        check("rst_o_eol", 32'(o_eol), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_i_rdy", 32'(i_rdy), 32'd1);
        sys_rst = 1'b0;
        idle(1);

        // Directed values: (sum p*w + 64) >> 7, clamped to 0..255.
        sendw(100, 100, 100, 100,  32,  32,  32,  32, 1'b1, 100,  0); // 12800 -> 100
        sendw(255,   0,   0, 255,  -8,  72,  72,  -8, 1'b0,   0,  1); // r=-32
        sendw(  0, 255, 255,   0,  -8,  72,  72,  -8, 1'b1, 255,  1); // r=287, sof reloads
        sendw( 10, 200, 150,  30, -10,  80,  70, -12, 1'b0, 203,  1); // 26040 -> 203
        sendw(255, 255,   0,   0,  64,  64,   0,   0, 1'b0, 255,  1); // r=255 exactly
        sendw(255, 255,  64,   0,  64,  64,   1,   0, 1'b0, 255,  2); // r=256
        sendw( 65,   0,   0,   0,  -1,   0,   0,   0, 1'b0,   0,  3); // r=-1
        sendw( 64,   0,   0,   0,  -1,   0,   0,   0, 1'b0,   0,  3); // r=0 exactly
        sendw(255, 255, 255, 255, 127, 127, 127, 127, 1'b0, 255,  4); // max positive
        sendw(255, 255, 255, 255,-128,-128,-128,-128, 1'b0,   0,  5); // max negative

        // Backpressure: 127*k+64 < 128*(k+1) for small k, so each output equals k.
        bp_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send(k, k, k, k, 0, 127, 0, 0, 1'b0, 1'b0, 1'b0, k);
        end
        bp_en = 1'b0;
        idle(1);
        o_rdy = 1'b1;
        idle(6);
        check("bp_sat_cnt", 32'(sat_cnt), 32'd5);
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Sideband: 1-pixel line, then a 4-pixel line with bubbles and a clamp on pixel 2.
        send(50, 50, 50, 50, 32, 32, 32, 32, 1'b1, 1'b1, 1'b1, 50);
        idle(1);
        send(10, 10, 10, 10, 32, 32, 32, 32, 1'b1, 1'b0, 1'b1, 10);
        idle(1);
        send(20, 20, 20, 20, 32, 32, 32, 32, 1'b0, 1'b0, 1'b1, 20);
        idle(1);
        send(0, 255, 255, 0, -8, 72, 72, -8, 1'b0, 1'b0, 1'b1, 255);
        idle(1);
        send(40, 40, 40, 40, 32, 32, 32, 32, 1'b0, 1'b1, 1'b1, 40);
        idle(5);
        check("sb_sat_cnt", 32'(sat_cnt), 32'd1);

        // Reset with three pixels stalled in the pipe: none of them may ever appear.
        o_rdy = 1'b0;
        send(11, 11, 11, 11, 32, 32, 32, 32, 1'b0, 1'b0, 1'b0, 11);
        send(22, 22, 22, 22, 32, 32, 32, 32, 1'b0, 1'b0, 1'b0, 22);
        send(33, 33, 33, 33, 32, 32, 32, 32, 1'b0, 1'b0, 1'b0, 33);
        check("pre_rst_o_vld", 32'(o_vld), 32'd1);
        sys_rst = 1'b1;
        idle(1);
        sys_rst = 1'b0;
        check("mid_rst_o_vld", 32'(o_vld), 32'd0);
        check("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        sb.delete();
        o_rdy = 1'b1;
        send(77, 77, 77, 77, 32, 32, 32, 32, 1'b0, 1'b0, 1'b1, 77);
        idle(8);
        check("post_rst_drained", 32'(sb.size()), 32'd0);

        // Saturation counter sticks at all-ones.
        for (int i = 0; i < 65534; i++) begin
            send(0, 255, 255, 0, -8, 72, 72, -8, 1'b0, 1'b0, 1'b1, 255);
        end
        idle(4);
        check("sat_cnt_fffe", 32'(sat_cnt), 32'hFFFE);
        send(0, 255, 255, 0, -8, 72, 72, -8, 1'b0, 1'b0, 1'b1, 255);
        idle(4);
        check("sat_cnt_ffff", 32'(sat_cnt), 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            send(0, 255, 255, 0, -8, 72, 72, -8, 1'b0, 1'b0, 1'b1, 255);
        end
        idle(4);
        check("sat_cnt_hold", 32'(sat_cnt), 32'hFFFF);

        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            idle(1);
        end
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
